// File: rtl/bcd_conv_sched_if.sv
// Request/grant and result bundle between the two value sources and the
// shared binary-to-BCD engine.
interface bcd_conv_sched_if #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
);
    logic                  req_a;
    logic [WIDTH-1:0]      bin_a;
    logic                  req_b;
    logic [WIDTH-1:0]      bin_b;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  busy;
    logic                  done;
    logic                  done_id;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output req_a, bin_a, req_b, bin_b,
        input  gnt_a, gnt_b, busy, done, done_id, bcd_out
    );

    modport slave (
        input  req_a, bin_a, req_b, bin_b,
        output gnt_a, gnt_b, busy, done, done_id, bcd_out
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Time-shared iterative double-dabble converter with a two-requester
// round-robin front end; one shift-and-adjust step per clock.
//
//   state   | meaning
//   IDLE    | waiting for a request; grant and operand capture happen here
//   SHIFT   | one add-3/shift step per cycle, WIDTH cycles
//   DONE    | result registered, done pulse, back to IDLE
module bcd_conv_sched #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    bcd_conv_sched_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [BW-1:0]    scr_q, scr_d;
    logic [BW-1:0]    adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             done_id_q, done_id_d;
    logic             pick_b;
    logic             grant;

    // ptr_q = 1 means B was granted last, so A wins the next contention
    always_comb begin
        pick_b = bus.req_b && (!bus.req_a || !ptr_q);
        grant  = rst_ni && (state_q == S_IDLE) && (bus.req_a || bus.req_b);
    end

    always_comb begin
        adj = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        bcd_d     = bcd_q;
        done_id_d = done_id_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    opnd_d  = pick_b ? bus.bin_b : bus.bin_a;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    owner_d = pick_b;
                    ptr_d   = pick_b;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Top bit of the adjusted scratch falls off; unreachable when 10^DIGITS > 2^WIDTH-1
                scr_d  = BW'({adj, opnd_q[WIDTH-1]});
                opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d     = BW'({adj, opnd_q[WIDTH-1]});
                    done_id_d = owner_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            opnd_q    <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b1;
            bcd_q     <= '0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            bcd_q     <= bcd_d;
            done_id_q <= done_id_d;
        end
    end

    assign bus.gnt_a   = grant && !pick_b;
    assign bus.gnt_b   = grant && pick_b;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.done_id = done_id_q;
    assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: scoreboard fed at grant time with a
// decimal-digit reference, drained on done.
module tb_bcd_conv_sched;
    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct packed {
        logic        id;
        logic [11:0] bcd;
    } exp_t;

    exp_t sb[$];

    bcd_conv_sched_if #(.WIDTH(7), .DIGITS(3)) bus ();

    bcd_conv_sched #(.WIDTH(7), .DIGITS(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Scoreboard: push on grant, pop on done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            check("gnt_in_reset", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd0);
        end else begin
            check("gnt_exclusive", bus.gnt_a & bus.gnt_b, 32'd0);
            if (bus.gnt_a) sb.push_back({1'b0, to_bcd(int'(bus.bin_a))});
            if (bus.gnt_b) sb.push_back({1'b1, to_bcd(int'(bus.bin_b))});
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_without_grant", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("done_id", bus.done_id, e.id);
                    check("bcd_out", bus.bcd_out, e.bcd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int t, output logic who);
        logic got;
        got = 1'b0;
        t   = -1;
        who = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.gnt_a || bus.gnt_b) begin
                got = 1'b1;
                t   = cyc;
                who = bus.gnt_b;
                break;
            end
        end
        check("grant_seen", got, 1);
    endtask

    task automatic run_one(input logic use_b, input int v, input string tag);
        int   t;
        logic who;
        step();
        if (use_b) begin bus.bin_b = 7'(v); bus.req_b = 1'b1; end
        else       begin bus.bin_a = 7'(v); bus.req_a = 1'b1; end
        wait_grant(t, who);
        check({tag, "_who"}, who, use_b);
        step();
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, bus.busy, 1);
            check({tag, "_done"}, bus.done, (k == 8));
        end
        @(negedge clk);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int   t, t2, td, prev;
        logic who, got;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.bin_a = '0;
        bus.bin_b = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_bcd", bus.bcd_out, 0);
        check("rst_done_id", bus.done_id, 0);
        step();
        rst_n = 1'b1;

        run_one(1'b0, 127, "a127");
        run_one(1'b1, 0, "b0");
        run_one(1'b1, 99, "b99");
        run_one(1'b1, 100, "b100");

        // Contention held from reset: A, B, A, B at 9-cycle spacing
        step();
        rst_n = 1'b0;
        bus.bin_a = 7'd45;
        bus.bin_b = 7'd9;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(t, who);
            check("rr_order", who, g % 2);
            if (g > 0) check("rr_spacing", t - prev, 9);
            prev = t;
        end
        step();
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (10) @(negedge clk);

        // Operand change after the grant edge must not affect the result
        step();
        bus.bin_a = 7'd64;
        bus.req_a = 1'b1;
        wait_grant(t, who);
        step();
        bus.req_a = 1'b0;
        step();
        bus.bin_a = 7'd5;
        got = 1'b0;
        td  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; td = cyc; break; end
        end
        check("mid_done_seen", got, 1);
        check("mid_done_time", td - t, 8);
        check("mid_bcd", bus.bcd_out, 12'h064);

        // Reset mid-conversion: no done, outputs cleared, A first afterwards
        step();
        bus.bin_a = 7'd20;
        bus.req_a = 1'b1;
        wait_grant(t, who);
        step();
        bus.req_a = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        check("mrst_bcd", bus.bcd_out, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("mrst_no_done", bus.done, 0);
        end
        step();
        bus.bin_a = 7'd33;
        bus.bin_b = 7'd77;
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        wait_grant(t, who);
        check("mrst_first_a", who, 0);
        step();
        bus.req_a = 1'b0;
        wait_grant(t2, who);
        check("mrst_then_b", who, 1);
        check("mrst_b_spacing", t2 - t, 9);
        step();
        bus.req_b = 1'b0;
        repeat (10) @(negedge clk);

        // Hold-off: B requests during A's conversion
        step();
        bus.bin_a = 7'd88;
        bus.req_a = 1'b1;
        wait_grant(t, who);
        step();
        bus.req_a = 1'b0;
        step();
        step();
        bus.bin_b = 7'd50;
        bus.req_b = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            check("holdoff_no_gnt_b", bus.gnt_b, 0);
        end
        @(negedge clk);
        check("holdoff_gnt_b", bus.gnt_b, 1);
        check("holdoff_gnt_time", cyc - t, 9);
        step();
        bus.req_b = 1'b0;
        repeat (12) @(negedge clk);
        check("final_bcd_hold", bus.bcd_out, 12'h050);
        check("final_done_id", bus.done_id, 1);
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Time-shared, iterative binary-to-BCD conversion engine with a two-requester round-robin front end. Two clients, the counter path (A) and the switch/display path (B), share one sequential double-dabble datapath instead of instantiating two combinational converters. The block sits between the value sources and the seven-segment decode stage. It accepts one operand at a time, runs one shift-and-adjust step per clock, and returns the packed BCD result with a done pulse tagged by requester.

## Interface
- WIDTH, 7: binary operand width.
- DIGITS, 3: number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; the default covers 0..127.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_a  input  1  requester A wants a conversion; held high until gnt_a.
- bin_a  input  WIDTH  requester A operand; must be stable while req_a is high.
- req_b  input  1  requester B wants a conversion; held high until gnt_b.
- bin_b  input  WIDTH  requester B operand; must be stable while req_b is high.
- gnt_a  output  1  one-cycle pulse; A's operand is captured this cycle.
- gnt_b  output  1  one-cycle pulse; B's operand is captured this cycle.
- busy  output  1  high while a conversion is in flight (SHIFT or DONE state).
- done  output  1  one-cycle pulse; bcd_out is valid and newly updated.
- done_id  output  1  0 = result belongs to A, 1 = result belongs to B; valid with done, held afterwards.
- bcd_out  output  4*DIGITS  packed result, least significant digit in [3:0]; holds the last result.

## Operation
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant one requester (combinational gnt_x in this cycle), latch its operand into the shift register, clear the BCD scratch register, load the bit counter with WIDTH, record the owner id, and go to SHIFT.
- Arbitration is round-robin on a last-granted pointer.
  - If both requesters are active, grant the one not granted last.
  - If one requester is active, grant it regardless of the pointer.
  - The pointer resets to B, so A wins the first contention after reset.
- SHIFT, one step per cycle:
  - Each scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits).
  - Then shift {scratch, operand} left by 1.
  - Decrement the counter.
  - When the step that brings the counter to 0 completes, go to DONE.
  - The state machine is in SHIFT for exactly WIDTH cycles.
- DONE:
  - bcd_out and done_id are loaded on entry, so they are valid during the DONE cycle.
  - done = 1 for this one cycle, then return to IDLE.
  - No grant is issued in DONE; a pending request is granted in the following IDLE cycle.
- Requests arriving while busy wait; they are never dropped while held.
- Requests deasserted before a grant are simply not served. No latching of request pulses.
- Arithmetic: the scratch register is 4*DIGITS bits. Bits shifted out of the top are discarded, which cannot happen when the DIGITS rule holds.
- Reset (rst_n low at an edge), including mid-conversion:
  - State goes to IDLE; the in-flight result is discarded with no done.
  - gnt_a = gnt_b = busy = done = 0; done_id = 0; bcd_out = 0; pointer = B.

## Timing
- Grant cycle = T. busy is high from T+1 through T+WIDTH+1.
- done is high at T+WIDTH+1, which is T+8 for the default.
- Earliest next grant: T+WIDTH+2. Sustained throughput is one conversion per WIDTH+2 cycles.
- gnt_a and gnt_b are never high together. gnt_x is high only in IDLE and only with req_x high.
- The operand is sampled only on the grant edge; later changes to bin_x do not affect the conversion in flight.
- bcd_out changes only at DONE entry or reset.

## Test plan
- Reset, then A alone: req_a with bin_a=127 → gnt_a at T; done at T+8 with done_id=0 and bcd_out=12'h127; busy high T+1..T+8.
- Edge values via B: bin_b=0 → 12'h000; bin_b=99 → 12'h099; bin_b=100 → 12'h100. Each completes with done_id=1.
- Contention: req_a and req_b held together from reset → grants alternate A, B, A, B, with grants spaced 9 cycles apart. Results are A=45 → 12'h045 and B=9 → 12'h009, each matched to its done_id.
- Operand change mid-flight: grant A with 64, then drive bin_a=5 at T+2 → result is still 12'h064.
- Reset mid-operation: rst_n low at T+4 → no done pulse; bcd_out=0, busy=0. After release, a simultaneous A/B request grants A first.
- Hold-off: req_b asserted at T+3 during A's conversion → gnt_b at T+9, never earlier, and not during the DONE cycle.
